// File: rtl/galvo_pkg.sv
// Shared definitions for the galvo DAC sequencer: FSM states, DAC word layout and
// the per-channel configuration nibbles of the dual 12-bit DAC.
package galvo_pkg;

    localparam int DAC_WORD_W = 16;
    localparam int DAC_CODE_W = 12;

    localparam logic [3:0] CFG_X_NIBBLE = 4'h3;
    localparam logic [3:0] CFG_Y_NIBBLE = 4'hB;

    typedef enum logic [2:0] {
        ST_HOLDOFF,
        ST_IDLE,
        ST_WAIT_X,
        ST_WAIT_Y,
        ST_LDAC
    } state_t;

    function automatic logic [DAC_WORD_W-1:0] dac_word(input logic [3:0]            cfg,
                                                       input logic [DAC_CODE_W-1:0] code);
        return {cfg, code};
    endfunction

endpackage

// File: rtl/point_rate_timer.sv
// Point-rate pacing timer: reloads on each accepted point, counts down and
// saturates at zero, which marks the period as expired.
module point_rate_timer #(
    parameter int unsigned PERIOD = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    output logic expired,
    output logic expire_next
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (reload)
            cnt_q <= CW'(PERIOD - 1);
        else if (cnt_q != '0)
            cnt_q <= cnt_q - CW'(1);
    end

    assign expired = (cnt_q == '0);
    // Lets the owner register a ready flag that is valid in the cycle the count hits zero.
    assign expire_next = (cnt_q <= CW'(1));

endmodule

// File: rtl/galvo_dac_sequencer.sv
// Sends one (x, y) point as two SPI words to the dual galvo DAC, then strobes LDAC_N
// so both mirrors move together; paces points and blanks the laser on starvation.
module galvo_dac_sequencer
    import galvo_pkg::*;
#(
    parameter int unsigned POINT_PERIOD = 2000,
    parameter int unsigned LDAC_WIDTH   = 4,
    parameter int unsigned SPI_HOLDOFF  = 256,
    parameter logic [3:0]  CFG_X        = CFG_X_NIBBLE,
    parameter logic [3:0]  CFG_Y        = CFG_Y_NIBBLE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DAC_CODE_W-1:0] in_x,
    input  logic [DAC_CODE_W-1:0] in_y,
    input  logic                  in_laser,
    output logic                  in_ready,
    output logic                  spi_start,
    output logic [DAC_WORD_W-1:0] spi_data,
    input  logic                  spi_done,
    output logic                  ldac_n,
    output logic                  laser_on,
    output logic                  busy,
    output logic                  underrun
);

    localparam int HW = $clog2(SPI_HOLDOFF + 1);
    localparam int LW = $clog2(LDAC_WIDTH + 1);

    state_t                  state_q, state_d;
    logic [HW-1:0]           holdoff_q, holdoff_d;
    logic [LW-1:0]           ldac_cnt_q, ldac_cnt_d;
    logic [DAC_CODE_W-1:0]   y_q, y_d;
    logic                    laser_q, laser_d;
    logic                    in_ready_d, spi_start_d, ldac_n_d, laser_on_d, busy_d, underrun_d;
    logic [DAC_WORD_W-1:0]   spi_data_d;
    logic                    accept, reload, expired, expire_next;

    point_rate_timer #(.PERIOD(POINT_PERIOD)) u_rate (
        .clk        (clk),
        .reset      (reset),
        .reload     (reload),
        .expired    (expired),
        .expire_next(expire_next)
    );

    assign accept = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d     = state_q;
        holdoff_d   = holdoff_q;
        ldac_cnt_d  = ldac_cnt_q;
        y_d         = y_q;
        laser_d     = laser_q;
        spi_start_d = 1'b0;
        spi_data_d  = spi_data;
        ldac_n_d    = ldac_n;
        laser_on_d  = laser_on;
        underrun_d  = 1'b0;
        reload      = 1'b0;

        unique case (state_q)
            ST_HOLDOFF: begin
                if (holdoff_q == HW'(SPI_HOLDOFF - 1))
                    state_d = ST_IDLE;
                else
                    holdoff_d = holdoff_q + HW'(1);
            end
            ST_IDLE: begin
                if (accept) begin
                    y_d         = in_y;
                    laser_d     = in_laser;
                    spi_data_d  = dac_word(CFG_X, in_x);
                    spi_start_d = 1'b1;
                    reload      = 1'b1;
                    state_d     = ST_WAIT_X;
                end else if (expired && !in_valid && laser_on) begin
                    laser_on_d = 1'b0;
                    underrun_d = 1'b1;
                end
            end
            ST_WAIT_X: begin
                if (spi_done) begin
                    spi_data_d  = dac_word(CFG_Y, y_q);
                    spi_start_d = 1'b1;
                    state_d     = ST_WAIT_Y;
                end
            end
            ST_WAIT_Y: begin
                if (spi_done) begin
                    ldac_n_d   = 1'b0;
                    laser_on_d = laser_q;
                    ldac_cnt_d = '0;
                    state_d    = ST_LDAC;
                end
            end
            ST_LDAC: begin
                if (ldac_cnt_q == LW'(LDAC_WIDTH - 1)) begin
                    ldac_n_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    ldac_cnt_d = ldac_cnt_q + LW'(1);
                end
            end
            default: state_d = ST_HOLDOFF;
        endcase

        in_ready_d = (state_d == ST_IDLE) && expire_next;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HOLDOFF;
            holdoff_q  <= '0;
            ldac_cnt_q <= '0;
            in_ready   <= 1'b0;
            spi_start  <= 1'b0;
            spi_data   <= '0;
            ldac_n     <= 1'b1;
            laser_on   <= 1'b0;
            busy       <= 1'b1;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_d;
            holdoff_q  <= holdoff_d;
            ldac_cnt_q <= ldac_cnt_d;
            in_ready   <= in_ready_d;
            spi_start  <= spi_start_d;
            spi_data   <= spi_data_d;
            ldac_n     <= ldac_n_d;
            laser_on   <= laser_on_d;
            busy       <= busy_d;
            underrun   <= underrun_d;
        end
    end

    // NOTE: the point latch carries no reset; it is always written on accept before it is read.
    always_ff @(posedge clk) begin
        y_q     <= y_d;
        laser_q <= laser_d;
    end

endmodule

// File: tb/tb_galvo_dac_sequencer.sv
// Directed bench for galvo_dac_sequencer: default instance plus a short-period instance,
// each driven by a fixed-latency SPI master model.
module tb_galvo_dac_sequencer;

    localparam int SPI_LAT = 20;
    localparam int HOLDOFF = 256;
    localparam int PERIOD  = 2000;
    localparam int FAST_P  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        f_valid = 1'b0;
    logic [11:0] in_x = '0;
    logic [11:0] in_y = '0;
    logic        in_laser = 1'b0;
    logic        force_done = 1'b0;

    logic        in_ready, spi_start, spi_done, ldac_n, laser_on, busy, underrun;
    logic [15:0] spi_data;
    logic        f_ready, f_start, f_done, f_ldac_n, f_laser_on, f_busy, f_underrun;
    logic [15:0] f_data;

    logic        m_done = 1'b0;
    int          m_cnt = 0;
    logic        fm_done = 1'b0;
    int          fm_cnt = 0;

    int          cyc = 0;
    int          acc_log[$];
    int          und_log[$];
    int          f_acc_log[$];
    logic [15:0] words[$];
    int          start_cnt = 0;
    int          start_long = 0;
    logic        start_prev = 1'b0;

    int checks = 0;
    int failures = 0;

    assign spi_done = m_done | force_done;
    assign f_done   = fm_done;

    galvo_dac_sequencer u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_laser(in_laser), .in_ready(in_ready), .spi_start(spi_start), .spi_data(spi_data),
        .spi_done(spi_done), .ldac_n(ldac_n), .laser_on(laser_on), .busy(busy), .underrun(underrun)
    );

    galvo_dac_sequencer #(.POINT_PERIOD(FAST_P)) u_fast (
        .clk(clk), .reset(reset), .in_valid(f_valid), .in_x(in_x), .in_y(in_y),
        .in_laser(in_laser), .in_ready(f_ready), .spi_start(f_start), .spi_data(f_data),
        .spi_done(f_done), .ldac_n(f_ldac_n), .laser_on(f_laser_on), .busy(f_busy), .underrun(f_underrun)
    );

    always #5 clk = ~clk;

    // SPI master models: done pulses SPI_LAT+1 edges after the start pulse is seen.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (spi_start) m_cnt <= SPI_LAT;
        else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        fm_done <= 1'b0;
        if (f_start) fm_cnt <= SPI_LAT;
        else if (fm_cnt != 0) begin
            fm_cnt <= fm_cnt - 1;
            if (fm_cnt == 1) fm_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) acc_log.push_back(cyc);
        if (f_valid && f_ready) f_acc_log.push_back(cyc);
        if (underrun) und_log.push_back(cyc);
        if (spi_start) begin
            words.push_back(spi_data);
            start_cnt <= start_cnt + 1;
        end
        if (spi_start && start_prev) start_long <= start_long + 1;
        start_prev <= spi_start;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic holdoff_walk(input string tag);
        int errs;
        errs = 0;
        for (int k = 1; k < HOLDOFF; k++) begin
            step();
            if (k == 10) in_valid = 1'b1;
            if (in_ready !== 1'b0 || spi_start !== 1'b0 || ldac_n !== 1'b1 || busy !== 1'b1) errs++;
        end
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL %s_quiet: bad cycles=%0d required=0", tag, errs);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_exit: in_ready=%b busy=%b required 1/0", tag, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (3) step();
        checks++;
        if ({in_ready, spi_start, spi_data, ldac_n, laser_on, busy, underrun} !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: rdy=%b start=%b data=%h ldac_n=%b laser=%b busy=%b und=%b required 0/0/0000/1/0/1/0",
                     in_ready, spi_start, spi_data, ldac_n, laser_on, busy, underrun);
        end
        in_x = 12'hABC;
        in_y = 12'h123;
        in_laser = 1'b1;
        reset = 1'b0;
        holdoff_walk("holdoff");
        checks++;
        if (start_cnt !== 0) begin
            failures++;
            $display("FAIL holdoff_starts: got=%0d required=0", start_cnt);
        end
    endtask

    task automatic test_point();
        int lowc;
        bit seen;
        step();
        in_valid = 1'b0;
        checks++;
        if (spi_start !== 1'b1 || spi_data !== 16'h3ABC || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL point_x_word: start=%b data=%h rdy=%b required 1/3abc/0", spi_start, spi_data, in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (spi_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || spi_data !== 16'hB123) begin
            failures++;
            $display("FAIL point_y_word: seen=%b data=%h required 1/b123", seen, spi_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (spi_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || laser_on !== 1'b0 || ldac_n !== 1'b1) begin
            failures++;
            $display("FAIL point_pre_ldac: done_seen=%b laser=%b ldac_n=%b required 1/0/1", seen, laser_on, ldac_n);
        end
        step();
        checks++;
        if (ldac_n !== 1'b0 || laser_on !== 1'b1) begin
            failures++;
            $display("FAIL point_ldac_fall: ldac_n=%b laser=%b required 0/1", ldac_n, laser_on);
        end
        lowc = 1;
        for (int i = 0; i < 20 && ldac_n === 1'b0; i++) begin
            step();
            if (ldac_n === 1'b0) lowc++;
        end
        checks++;
        if (lowc !== 4) begin
            failures++;
            $display("FAIL point_ldac_width: got=%0d required=4", lowc);
        end
        checks++;
        if (start_cnt !== 2 || start_long !== 0 || words[0] !== 16'h3ABC || words[1] !== 16'hB123) begin
            failures++;
            $display("FAIL point_spi_log: starts=%0d wide=%0d w0=%h w1=%h required 2/0/3abc/b123",
                     start_cnt, start_long, words[0], words[1]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        in_x = 12'h555;
        in_y = 12'hAAA;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8000 && !ok; i++) begin
            step();
            if (acc_log.size() >= 4) ok = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout: accepts=%0d required=4", acc_log.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc_log[i] - acc_log[i-1] !== PERIOD) begin
                    failures++;
                    $display("FAIL b2b_spacing%0d: got=%0d required=%0d", i, acc_log[i] - acc_log[i-1], PERIOD);
                end
            end
        end
    endtask

    task automatic test_starvation();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2500 && !ok; i++) begin
            step();
            if (und_log.size() >= 1) ok = 1'b1;
        end
        checks++;
        if (!ok || und_log[0] - acc_log[3] !== PERIOD + 1) begin
            failures++;
            $display("FAIL starve_timing: seen=%b offset=%0d required=%0d", ok,
                     ok ? und_log[0] - acc_log[3] : -1, PERIOD + 1);
        end
        checks++;
        if (laser_on !== 1'b0 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL starve_blank: laser=%b underrun=%b required 0/0", laser_on, underrun);
        end
        repeat (5000) step();
        checks++;
        if (und_log.size() !== 1 || laser_on !== 1'b0) begin
            failures++;
            $display("FAIL starve_single: pulses=%0d laser=%b required 1/0", und_log.size(), laser_on);
        end
    endtask

    task automatic test_spurious_done();
        int s0, w0, lowc;
        bit seen;
        s0 = start_cnt;
        w0 = words.size();
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || spi_start !== 1'b0) begin
            failures++;
            $display("FAIL spur_idle: busy=%b rdy=%b start=%b required 0/1/0", busy, in_ready, spi_start);
        end
        in_x = 12'h000;
        in_y = 12'hFFF;
        in_laser = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            if (ldac_n === 1'b0) seen = 1'b1;
        end
        lowc = seen ? 1 : 0;
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        if (ldac_n === 1'b0) lowc++;
        for (int i = 0; i < 20 && ldac_n === 1'b0; i++) begin
            step();
            if (ldac_n === 1'b0) lowc++;
        end
        checks++;
        if (lowc !== 4 || busy !== 1'b0) begin
            failures++;
            $display("FAIL spur_ldac: low_cycles=%0d busy=%b required 4/0", lowc, busy);
        end
        repeat (3) step();
        checks++;
        if (start_cnt - s0 !== 2 || words[w0] !== 16'h3000 || words[w0+1] !== 16'hBFFF || laser_on !== 1'b0) begin
            failures++;
            $display("FAIL spur_words: starts=%0d w0=%h w1=%h laser=%b required 2/3000/bfff/0",
                     start_cnt - s0, words[w0], words[w0+1], laser_on);
        end
    endtask

    task automatic test_reset_wait_y();
        int a0, s0, u0;
        bit ok;
        a0 = acc_log.size();
        s0 = start_cnt;
        u0 = und_log.size();
        in_x = 12'hFFF;
        in_y = 12'h000;
        in_laser = 1'b1;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            step();
            if (start_cnt >= s0 + 4) ok = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok || acc_log.size() - a0 !== 2 || laser_on !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_setup: reached=%b accepts=%0d laser=%b busy=%b required 1/2/1/1",
                     ok, acc_log.size() - a0, laser_on, busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (laser_on !== 1'b0 || ldac_n !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_y: laser=%b ldac_n=%b busy=%b rdy=%b required 0/1/1/0",
                     laser_on, ldac_n, busy, in_ready);
        end
        s0 = start_cnt;
        in_valid = 1'b0;
        holdoff_walk("rst_holdoff");
        in_valid = 1'b0;
        checks++;
        if (start_cnt !== s0 || und_log.size() !== u0) begin
            failures++;
            $display("FAIL rst_late_done: extra_starts=%0d extra_underruns=%0d required 0/0",
                     start_cnt - s0, und_log.size() - u0);
        end
    endtask

    task automatic test_fast_period();
        bit ok;
        f_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            step();
            if (f_acc_log.size() >= 2) ok = 1'b1;
        end
        f_valid = 1'b0;
        checks++;
        if (!ok || f_acc_log[1] - f_acc_log[0] !== 2 * SPI_LAT + 9) begin
            failures++;
            $display("FAIL fast_idle_entry: seen=%b spacing=%0d required=%0d", ok,
                     ok ? f_acc_log[1] - f_acc_log[0] : -1, 2 * SPI_LAT + 9);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_point();
        test_back_to_back();
        test_starvation();
        test_spurious_done();
        test_reset_wait_y();
        test_fast_period();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
